// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_pkg
// Description : Shared widths, tdata field positions and beat packing helper
//               for the spike inter-spike-interval calculator.
// Revision    : 1.0
// ============================================================================
package spike_pkg;

    localparam int c_TDATA_W       = 32;
    localparam int c_TS_W          = 28;
    localparam int c_DELTA_W       = 27;
    localparam int c_LINE_W        = 4;
    localparam int c_NUM_LINES     = 16;
    localparam int c_LINE_MSB      = 31;
    localparam int c_LINE_LSB      = 28;
    localparam int c_FIRST_BIT     = 27;
    localparam int c_DELTA_FIELD_W = 27;

    typedef logic [c_LINE_W-1:0] line_id_t;

    typedef struct packed {
        line_id_t                   line_id;
        logic                       first;
        logic [c_DELTA_FIELD_W-1:0] delta;
    } isi_beat_t;

    function automatic logic [c_TDATA_W-1:0] pack_isi(
        input line_id_t                   line_id,
        input logic                       first,
        input logic [c_DELTA_FIELD_W-1:0] delta
    );
        isi_beat_t beat;
        beat.line_id = line_id;
        beat.first   = first;
        beat.delta   = delta;
        return beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_interval_calc_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_interval_calc_if
// Description : Timestamp input stream and interval output stream bundle.
// Revision    : 1.0
// ============================================================================
interface spike_interval_calc_if;

    logic [spike_pkg::c_TDATA_W-1:0] ts_strm_tdata;
    logic                            ts_strm_tvalid;
    logic                            ts_strm_tready;
    logic [spike_pkg::c_TDATA_W-1:0] isi_strm_tdata;
    logic                            isi_strm_tvalid;
    logic                            isi_strm_tready;

    modport master (
        output ts_strm_tdata,
        output ts_strm_tvalid,
        input  ts_strm_tready,
        input  isi_strm_tdata,
        input  isi_strm_tvalid,
        output isi_strm_tready
    );

    modport slave (
        input  ts_strm_tdata,
        input  ts_strm_tvalid,
        output ts_strm_tready,
        output isi_strm_tdata,
        output isi_strm_tvalid,
        input  isi_strm_tready
    );

endinterface
`default_nettype wire

// File: rtl/isi_delta_sat.sv
`default_nettype none
// ============================================================================
// Module      : isi_delta_sat
// Description : Modular timestamp difference, saturated to the delta width.
// Revision    : 1.0
// ============================================================================
module isi_delta_sat #(
    parameter int TS_W    = 28,
    parameter int DELTA_W = 27
) (
    input  wire logic [TS_W-1:0]    i_ts,
    input  wire logic [TS_W-1:0]    i_last,
    output logic      [DELTA_W-1:0] o_delta
);

    // Subtraction in TS_W bits wraps naturally with the timestamp counter
    logic [TS_W-1:0] w_raw;
    assign w_raw = i_ts - i_last;

    generate
        if (TS_W > DELTA_W) begin : g_sat
            logic w_over;
            assign w_over  = |w_raw[TS_W-1:DELTA_W];
            assign o_delta = w_over ? {DELTA_W{1'b1}} : w_raw[DELTA_W-1:0];
        end else begin : g_pass
            assign o_delta = DELTA_W'(w_raw);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spike_interval_calc.sv
`default_nettype none
// ============================================================================
// Module      : spike_interval_calc
// Description : Per-line inter-spike interval calculator with a single
//               full-throughput output register and a wrapping beat counter.
// Revision    : 1.0
// ============================================================================
module spike_interval_calc
    import spike_pkg::*;
#(
    parameter int TS_W    = c_TS_W,
    parameter int DELTA_W = c_DELTA_W
) (
    input  wire logic              ts_strm_clk,
    input  wire logic              resetn,
    spike_interval_calc_if.slave   strm,
    input  wire logic              table_clr,
    output logic [31:0]            beat_count
);

    logic [TS_W-1:0]        r_last [c_NUM_LINES];
    logic [c_NUM_LINES-1:0] r_seen;
    logic                   r_out_valid;
    logic [c_TDATA_W-1:0]   r_out_data;
    logic [31:0]            r_beat_count;

    logic                       w_accept;
    line_id_t                   w_line;
    logic [TS_W-1:0]            w_ts;
    logic                       w_first;
    logic [DELTA_W-1:0]         w_delta;
    logic [c_DELTA_FIELD_W-1:0] w_delta_field;
    logic [c_NUM_LINES-1:0]     w_line_hot;
    logic [c_NUM_LINES-1:0]     w_seen_next;

    assign strm.ts_strm_tready = !r_out_valid || strm.isi_strm_tready;
    assign w_accept            = strm.ts_strm_tvalid && strm.ts_strm_tready;

    assign w_line = strm.ts_strm_tdata[c_LINE_MSB:c_LINE_LSB];
    assign w_ts   = strm.ts_strm_tdata[TS_W-1:0];

    // A clear in the same cycle as the beat makes that beat the line's first
    assign w_first = !r_seen[w_line] || table_clr;

    isi_delta_sat #(
        .TS_W    (TS_W),
        .DELTA_W (DELTA_W)
    ) u_delta (
        .i_ts    (w_ts),
        .i_last  (r_last[w_line]),
        .o_delta (w_delta)
    );

    assign w_delta_field = w_first ? '0 : c_DELTA_FIELD_W'(w_delta);

    assign w_line_hot  = {{(c_NUM_LINES-1){1'b0}}, 1'b1} << w_line;
    assign w_seen_next = (table_clr ? '0 : r_seen) | (w_accept ? w_line_hot : '0);

    always_ff @(posedge ts_strm_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < c_NUM_LINES; i++) begin
                r_last[i] <= '0;
            end
            r_seen <= '0;
        end else begin
            r_seen <= w_seen_next;
            if (w_accept) begin
                r_last[w_line] <= w_ts;
            end
        end
    end

    // Output register holds its beat until taken; a new beat may replace it on the same edge
    always_ff @(posedge ts_strm_clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= pack_isi(w_line, w_first, w_delta_field);
                r_beat_count <= r_beat_count + 32'd1;
            end else if (strm.isi_strm_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign strm.isi_strm_tvalid = r_out_valid;
    assign strm.isi_strm_tdata  = r_out_data;
    assign beat_count           = r_beat_count;

endmodule
`default_nettype wire
